// File: rtl/d_hazard_ctrl_pkg.sv
// Shared types and helpers for the D-stage hazard/forwarding controller:
// shadow stage entry, forwarding select codes and producer/hazard tests.
package d_hazard_ctrl_pkg;

  localparam int TW_DEF = 2;

  localparam logic [TW_DEF-1:0] TUSE_NONE = TW_DEF'(3);

  // D-side forwarding selects
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  // E-side forwarding selects
  localparam logic [1:0] FWD_ID  = 2'd0;
  localparam logic [1:0] FWD_M_E = 2'd1;
  localparam logic [1:0] FWD_W   = 2'd2;

  typedef struct packed {
    logic [4:0]        wa;
    logic              we;
    logic [TW_DEF-1:0] tnew;
    logic [4:0]        rs;
    logic [4:0]        rt;
  } hz_entry_t;

  // $0 is hard-wired, so it never produces a value worth waiting for.
  function automatic logic produces(hz_entry_t e, logic [4:0] r);
    return e.we && (e.wa == r) && (r != 5'd0);
  endfunction

  function automatic logic data_hz(hz_entry_t e, hz_entry_t m, logic [4:0] r,
                                   logic [TW_DEF-1:0] tuse);
    return (tuse != TUSE_NONE) &&
           ((produces(e, r) && (e.tnew > tuse)) ||
            (produces(m, r) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] fwd_d_sel(hz_entry_t e, hz_entry_t m, logic [4:0] r);
    if (produces(e, r) && (e.tnew == '0))      return FWD_E;
    else if (produces(m, r) && (m.tnew == '0)) return FWD_M;
    else                                       return FWD_GRF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(hz_entry_t m, hz_entry_t w, logic [4:0] r);
    if (produces(m, r) && (m.tnew == '0)) return FWD_M_E;
    else if (produces(w, r))              return FWD_W;
    else                                  return FWD_ID;
  endfunction

endpackage

// File: rtl/d_hazard_ctrl_stage.sv
// One shadow pipeline entry: loads the previous stage, optionally inserts a
// bubble, and optionally saturating-decrements tnew on the way in.
module hz_stage_reg
  import d_hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble,
  input  logic      dec,
  input  hz_entry_t din,
  output hz_entry_t q
);

  hz_entry_t nxt;

  always_comb begin
    nxt = din;
    if (dec && (din.tnew != '0))
      nxt.tnew = din.tnew - TW_DEF'(1);
  end

  // NOTE: state registers use non-blocking assignments so all three stages
  // shift on the same edge without ordering races between instances.
  always_ff @(posedge clk) begin
    if (!reset)      q <= '0;
    else if (bubble) q <= '0;
    else             q <= nxt;
  end

endmodule

// File: rtl/d_hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight writers in E/M/W and
// derives the D-stall, forwarding selects and a stall-cycle counter.
module d_hazard_ctrl
  import d_hazard_ctrl_pkg::*;
#(
  parameter int TW   = 2,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      d_rs,
  input  logic [4:0]      d_rt,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic [4:0]      d_wa,
  input  logic            d_we,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md,
  input  logic            e_md_busy,
  output logic            stall,
  output logic [1:0]      fwd_d_rs,
  output logic [1:0]      fwd_d_rt,
  output logic [1:0]      fwd_e_rs,
  output logic [1:0]      fwd_e_rt,
  output logic [CNTW-1:0] stall_cnt
);

  hz_entry_t d_entry, e_q, m_q, w_q;

  assign d_entry = '{wa: d_wa, we: d_we, tnew: d_tnew, rs: d_rs, rt: d_rt};

  hz_stage_reg u_e (.clk(clk), .reset(reset), .bubble(stall), .dec(1'b0), .din(d_entry), .q(e_q));
  hz_stage_reg u_m (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b1), .din(e_q),     .q(m_q));
  hz_stage_reg u_w (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b0), .din(m_q),     .q(w_q));

  // W is always ready and its operands are never consulted again.
  logic w_fields_unused;
  assign w_fields_unused = ^{w_q.tnew, w_q.rs, w_q.rt};

  assign stall = data_hz(e_q, m_q, d_rs, d_tuse_rs) ||
                 data_hz(e_q, m_q, d_rt, d_tuse_rt) ||
                 (d_md && e_md_busy);

  assign fwd_d_rs = fwd_d_sel(e_q, m_q, d_rs);
  assign fwd_d_rt = fwd_d_sel(e_q, m_q, d_rt);
  assign fwd_e_rs = fwd_e_sel(m_q, w_q, e_q.rs);
  assign fwd_e_rt = fwd_e_sel(m_q, w_q, e_q.rt);

  always_ff @(posedge clk) begin
    if (!reset)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Self-checking bench for d_hazard_ctrl: a table of per-cycle D-stage
// vectors with hand-derived expectations, plus md-stall and reset sequences.
module tb_d_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_we, d_md, e_md_busy;
  logic        stall;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [31:0] stall_cnt;

  d_hazard_ctrl #(.TW(2), .CNTW(32)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wa(d_wa), .d_we(d_we), .d_tnew(d_tnew), .d_md(d_md), .e_md_busy(e_md_busy),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, wa;
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic       we, md, busy;
    logic       stall;
    logic [1:0] fdrs, fdrt, fers, fert;
    int         cnt;
  } vec_t;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] fdrs, fdrt, fers, fert;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, int rs, int rt, int tus, int tut, int wa, int we,
                              int tn, int st, int fdrs, int fdrt, int fers, int fert, int cnt);
    vec_t v;
    v.name = n;
    v.rs = 5'(rs); v.rt = 5'(rt); v.tuse_rs = 2'(tus); v.tuse_rt = 2'(tut);
    v.wa = 5'(wa); v.we = 1'(we); v.tnew = 2'(tn);
    v.md = 1'b0; v.busy = 1'b0;
    v.stall = 1'(st); v.fdrs = 2'(fdrs); v.fdrt = 2'(fdrt);
    v.fers = 2'(fers); v.fert = 2'(fert); v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t nop(string n, int fers, int fert, int cnt);
    return mk(n, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, fers, fert, cnt);
  endfunction

  // Drive one D-stage vector after the edge, score it on the falling edge.
  task automatic apply_and_check(input vec_t v);
    exp_t e, got;
    d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.tuse_rs; d_tuse_rt = v.tuse_rt;
    d_wa = v.wa; d_we = v.we; d_tnew = v.tnew; d_md = v.md; e_md_busy = v.busy;
    e.name = v.name; e.stall = v.stall; e.fdrs = v.fdrs; e.fdrt = v.fdrt;
    e.fers = v.fers; e.fert = v.fert; e.cnt = v.cnt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      got = sb.pop_front();
      check({got.name, ".stall"},    32'(stall),    32'(got.stall));
      check({got.name, ".fwd_d_rs"}, 32'(fwd_d_rs), 32'(got.fdrs));
      check({got.name, ".fwd_d_rt"}, 32'(fwd_d_rt), 32'(got.fdrt));
      check({got.name, ".fwd_e_rs"}, 32'(fwd_e_rs), 32'(got.fers));
      check({got.name, ".fwd_e_rt"}, 32'(fwd_e_rt), 32'(got.fert));
      check({got.name, ".stall_cnt"}, stall_cnt,    32'(got.cnt));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    advance();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;

    // Load-use, branch-after-ALU on rt, $0, younger-writer priority, tnew=0 producer.
    tbl.push_back(mk("lu_lw",      29, 0, 1, 3,  8, 1, 2,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lu_stall",    8, 9, 1, 1, 10, 1, 1,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lu_release",  8, 9, 1, 1, 10, 1, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(nop("lu_fwd_w", 2, 0, 1));
    tbl.push_back(nop("lu_nop1",  0, 0, 1));
    tbl.push_back(nop("lu_nop2",  0, 0, 1));
    tbl.push_back(mk("br_addu",     1, 2, 1, 1,  9, 1, 1,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("br_stall",    0, 9, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("br_fwd_m",    0, 9, 0, 0,  0, 0, 0,  0, 0, 2, 0, 0, 2));
    tbl.push_back(nop("br_e_w",   0, 2, 2));
    tbl.push_back(nop("br_nop",   0, 0, 2));
    tbl.push_back(mk("z_lw0",      29, 0, 1, 3,  0, 1, 2,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("z_use0",      0, 0, 0, 0,  3, 1, 1,  0, 0, 0, 0, 0, 2));
    tbl.push_back(nop("z_nop1",   0, 0, 2));
    tbl.push_back(nop("z_nop2",   0, 0, 2));
    tbl.push_back(nop("z_nop3",   0, 0, 2));
    tbl.push_back(mk("pr_addu",     1, 2, 1, 1,  5, 1, 1,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("pr_ori",      3, 0, 1, 3,  5, 1, 1,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("pr_use",      5, 0, 1, 3,  6, 1, 1,  0, 2, 0, 0, 0, 2));
    tbl.push_back(nop("pr_e_m",   1, 0, 2));
    tbl.push_back(nop("pr_nop",   0, 0, 2));
    tbl.push_back(mk("e0_lui",      0, 0, 3, 3, 12, 1, 0,  0, 0, 0, 0, 0, 2));
    tbl.push_back(mk("e0_use",     12, 12, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 2));
    tbl.push_back(nop("e0_e_m",   1, 1, 2));
    tbl.push_back(nop("e0_nop",   0, 0, 2));

    reset = 1'b0;
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_wa = '0; d_we = 1'b0; d_tnew = '0; d_md = 1'b0; e_md_busy = 1'b0;
    advance();
    advance();
    reset = 1'b1;
    apply_and_check(nop("reset_state", 0, 0, 0));
    advance();

    for (int i = 0; i < tbl.size(); i++) begin
      apply_and_check(tbl[i]);
      advance();
    end

    // Mult/div: five busy cycles stall five times and E only ever sees bubbles,
    // so the self-referencing D instruction is free once busy drops.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      v = mk($sformatf("md_busy%0d", i), 7, 0, 1, 3, 7, 1, 2, 1, 0, 0, 0, 0, i);
      v.md = 1'b1; v.busy = 1'b1;
      apply_and_check(v);
      advance();
    end
    v = mk("md_done", 7, 0, 1, 3, 7, 1, 2, 0, 0, 0, 0, 0, 5);
    v.md = 1'b1;
    apply_and_check(v);
    advance();

    // Reset while a load-use stall is active.
    apply_and_check(mk("rs_lw",    29, 0, 1, 3,  8, 1, 2, 0, 0, 0, 0, 0, 5));
    advance();
    apply_and_check(mk("rs_stall",  8, 0, 1, 3, 10, 1, 1, 1, 0, 0, 0, 0, 5));
    pulse_reset();
    apply_and_check(mk("rs_after",  8, 0, 1, 3, 10, 1, 1, 0, 0, 0, 0, 0, 0));
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
